// File: rtl/i281_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// i281_ctrl_pkg
// Shared control definitions for the multicycle i281 core:
//   - state_t        : fetch/execute sequencer states (3-bit encoding)
//   - OP_*           : 4-bit opcode values found in instr[15:12]
//   - MC_MASK_DEFAULT: opcodes that need the multicycle load/store/input unit
//   - is_multicycle(): opcode classification against a multicycle mask
// -----------------------------------------------------------------------------
package i281_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        EXEC    = 3'd2,
        MC_WAIT = 3'd3,
        HALT    = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOOP   = 4'h0;
    localparam logic [3:0] OP_INPUT  = 4'h1;
    localparam logic [3:0] OP_MOVE   = 4'h2;
    localparam logic [3:0] OP_LOADI  = 4'h3;
    localparam logic [3:0] OP_ADD    = 4'h4;
    localparam logic [3:0] OP_ADDI   = 4'h5;
    localparam logic [3:0] OP_SUB    = 4'h6;
    localparam logic [3:0] OP_SUBI   = 4'h7;
    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_LOADF  = 4'h9;
    localparam logic [3:0] OP_STORE  = 4'hA;
    localparam logic [3:0] OP_STOREF = 4'hB;
    localparam logic [3:0] OP_SHIFT  = 4'hC;
    localparam logic [3:0] OP_CMP    = 4'hD;
    localparam logic [3:0] OP_JUMP   = 4'hE;
    localparam logic [3:0] OP_BRANCH = 4'hF;

    // INPUT, LOAD, LOADF, STORE and STOREF go through the multicycle unit.
    localparam logic [15:0] MC_MASK_DEFAULT = 16'h0F02;

    // One mask bit per opcode: set means the opcode is handed to the multicycle unit.
    function automatic logic is_multicycle(input logic [15:0] mask,
                                           input logic [3:0]  opcode);
        return mask[opcode];
    endfunction

endpackage

// File: rtl/pc_update.sv
// -----------------------------------------------------------------------------
// pc_update
// Next-PC arithmetic for the i281 core. Purely combinational.
//   pc              in  6   current program counter
//   offset          in  6   branch offset (two's complement by natural wrap)
//   c2              in  1   branch taken
//   multicycle_flag in  1   a multicycle instruction is in progress
//   trigger         in  1   multicycle instruction completes this cycle
//   next_pc         out 6   candidate value for the PC register
// While a multicycle instruction is pending the PC only advances by one on
// its completion trigger and the branch flag plays no part. Otherwise the PC
// advances by one, plus the offset when the branch is taken. All arithmetic
// is modulo 64, so an offset of 6'h3F acts as -1.
// -----------------------------------------------------------------------------
module pc_update (
    input  logic [5:0] pc,
    input  logic [5:0] offset,
    input  logic       c2,
    input  logic       multicycle_flag,
    input  logic       trigger,
    output logic [5:0] next_pc
);

    // Select the sequential or branch target for the PC.
    always_comb begin
        next_pc = pc;
        if (multicycle_flag) begin
            if (trigger) begin
                next_pc = pc + 6'd1;
            end else begin
                next_pc = pc;
            end
        end else begin
            if (c2) begin
                next_pc = pc + 6'd1 + offset;
            end else begin
                next_pc = pc + 6'd1;
            end
        end
    end

endmodule

// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
// Fetch/execute control FSM of the multicycle i281 core. Owns the PC and the
// instruction register, classifies each fetched opcode and hands multicycle
// opcodes to the load/store/input unit through mc_start / exec_done.
//
// Ports:
//   clk                in  1   system clock, rising edge
//   rst_n              in  1   synchronous active-low reset
//   run_en             in  1   allow new fetches (looked at in IDLE and FETCH)
//   halt_req           in  1   stop at the next instruction boundary
//   instr              in  16  instruction memory data at address pc
//   c2                 in  1   branch taken, meaningful during EXEC
//   exec_done          in  1   multicycle unit completion, meaningful in MC_WAIT
//   pc                 out 6   current PC / instruction memory address
//   ir                 out 16  latched instruction
//   ir_valid           out 1   ir holds the instruction being executed
//   mc_start           out 1   one-cycle pulse in the first MC_WAIT cycle
//   multicycle_flag    out 1   high throughout MC_WAIT
//   next_instr_trigger out 1   high in the MC_WAIT cycle that sees exec_done
//   halted             out 1   sequencer is in HALT
//   mc_timeout         out 1   sticky: a multicycle instruction was aborted
// -----------------------------------------------------------------------------
module pc_sequencer
    import i281_ctrl_pkg::*;
#(
    parameter logic [15:0] MC_MASK    = MC_MASK_DEFAULT,
    parameter int          MC_TIMEOUT = 15,
    parameter int          TMR_W      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_en,
    input  logic        halt_req,
    input  logic [15:0] instr,
    input  logic        c2,
    input  logic        exec_done,
    output logic [5:0]  pc,
    output logic [15:0] ir,
    output logic        ir_valid,
    output logic        mc_start,
    output logic        multicycle_flag,
    output logic        next_instr_trigger,
    output logic        halted,
    output logic        mc_timeout
);

    localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(MC_TIMEOUT);

    state_t             state_r;
    logic [5:0]         pc_r;
    logic [15:0]        ir_r;
    logic [TMR_W-1:0]   tmr_r;
    logic               mc_start_r;
    logic               mc_timeout_r;

    logic               in_exec_s;
    logic               in_mc_wait_s;
    logic               trigger_s;
    logic               c2_gated_s;
    logic               pc_we_s;
    logic [5:0]         next_pc_s;
    logic [TMR_W-1:0]   tmr_next_s;
    logic               tmr_expire_s;

    // State decodes and the multicycle completion / timeout conditions.
    always_comb begin
        in_exec_s    = (state_r == EXEC);
        in_mc_wait_s = (state_r == MC_WAIT);
        // Completion is combinational on exec_done so the PC can advance in
        // the same cycle the multicycle unit reports done.
        trigger_s    = in_mc_wait_s & exec_done;
        // The branch flag only matters for single-cycle execution.
        c2_gated_s   = c2 & in_exec_s;
        pc_we_s      = in_exec_s | trigger_s;
        tmr_next_s   = tmr_r + {{(TMR_W-1){1'b0}}, 1'b1};
        // Abort once this wait cycle would bring the counter to the limit;
        // exec_done in that same cycle still completes normally.
        tmr_expire_s = (tmr_next_s == TMR_LIMIT);
    end

    pc_update u_pc_update (
        .pc              (pc_r),
        .offset          (ir_r[5:0]),
        .c2              (c2_gated_s),
        .multicycle_flag (in_mc_wait_s),
        .trigger         (trigger_s),
        .next_pc         (next_pc_s)
    );

    // Sequencer FSM with PC, IR, wait counter and registered status flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            pc_r         <= 6'd0;
            ir_r         <= 16'h0000;
            tmr_r        <= '0;
            mc_start_r   <= 1'b0;
            mc_timeout_r <= 1'b0;
        end else begin
            mc_start_r <= 1'b0;

            if (pc_we_s) begin
                pc_r <= next_pc_s;
            end

            case (state_r)
                IDLE: begin
                    if (halt_req) begin
                        state_r <= HALT;
                    end else if (run_en) begin
                        state_r <= FETCH;
                    end else begin
                        state_r <= IDLE;
                    end
                end

                FETCH: begin
                    if (!run_en) begin
                        state_r <= IDLE;
                    end else begin
                        ir_r  <= instr;
                        tmr_r <= '0;
                        // Classify from the live memory data; ir only
                        // holds it from the next cycle on.
                        if (is_multicycle(MC_MASK, instr[15:12])) begin
                            state_r    <= MC_WAIT;
                            mc_start_r <= 1'b1;
                        end else begin
                            state_r <= EXEC;
                        end
                    end
                end

                EXEC: begin
                    if (halt_req) begin
                        state_r <= HALT;
                    end else begin
                        state_r <= FETCH;
                    end
                end

                MC_WAIT: begin
                    if (exec_done) begin
                        if (halt_req) begin
                            state_r <= HALT;
                        end else begin
                            state_r <= FETCH;
                        end
                    end else if (tmr_expire_s) begin
                        tmr_r        <= tmr_next_s;
                        mc_timeout_r <= 1'b1;
                        state_r      <= HALT;
                    end else begin
                        tmr_r   <= tmr_next_s;
                        state_r <= MC_WAIT;
                    end
                end

                HALT: begin
                    state_r <= HALT;
                end

                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign pc                 = pc_r;
    assign ir                 = ir_r;
    assign ir_valid           = in_exec_s | in_mc_wait_s;
    assign mc_start           = mc_start_r;
    assign multicycle_flag    = in_mc_wait_s;
    assign next_instr_trigger = trigger_s;
    assign halted             = (state_r == HALT);
    assign mc_timeout         = mc_timeout_r;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
// Self-checking bench for pc_sequencer. Expected values come from an
// instruction-level reference: each instruction takes one fetch cycle and then
// either one execute cycle or a bounded wait for the multicycle unit; the
// expected PC is computed with plain modulo-64 arithmetic.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        run_en;
    logic        halt_req;
    logic [15:0] instr;
    logic        c2;
    logic        exec_done;
    logic [5:0]  pc;
    logic [15:0] ir;
    logic        ir_valid;
    logic        mc_start;
    logic        multicycle_flag;
    logic        next_instr_trigger;
    logic        halted;
    logic        mc_timeout;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state
    logic [15:0] model_mask = 16'h0F02;
    int          m_pc  = 0;
    bit          m_halted = 1'b0;
    bit          m_to  = 1'b0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .run_en             (run_en),
        .halt_req           (halt_req),
        .instr              (instr),
        .c2                 (c2),
        .exec_done          (exec_done),
        .pc                 (pc),
        .ir                 (ir),
        .ir_valid           (ir_valid),
        .mc_start           (mc_start),
        .multicycle_flag    (multicycle_flag),
        .next_instr_trigger (next_instr_trigger),
        .halted             (halted),
        .mc_timeout         (mc_timeout)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // One instruction, entered just after the edge that put the DUT in FETCH.
    // done_at: MC_WAIT cycle (1-based) in which exec_done is raised; >15 never.
    task automatic do_instr(input logic [15:0] ins, input bit c2v,
                            input int done_at, input bit hreq);
        bit mc;
        mc = model_mask[ins[15:12]];
        instr     = ins;
        run_en    = 1'b1;
        halt_req  = 1'($urandom_range(0, 1));
        exec_done = 1'($urandom_range(0, 1));
        c2        = 1'($urandom_range(0, 1));
        samp();
        check("fetch_pc", pc, m_pc);
        check("fetch_irv", ir_valid, 0);
        check("fetch_mcf", multicycle_flag, 0);
        check("fetch_halted", halted, 0);
        check("fetch_to", mc_timeout, m_to);
        tick();
        instr = 16'($urandom);
        if (!mc) begin
            c2        = c2v;
            halt_req  = hreq;
            exec_done = 1'($urandom_range(0, 1));
            run_en    = 1'($urandom_range(0, 1));
            samp();
            check("exec_ir", ir, ins);
            check("exec_irv", ir_valid, 1);
            check("exec_mcs", mc_start, 0);
            check("exec_mcf", multicycle_flag, 0);
            check("exec_trig", next_instr_trigger, 0);
            tick();
            m_pc = (m_pc + 1 + (c2v ? int'(ins[5:0]) : 0)) % 64;
            if (hreq) m_halted = 1'b1;
        end else begin
            for (int k = 1; k <= 15; k++) begin
                exec_done = (k == done_at);
                c2        = 1'b1;
                halt_req  = hreq;
                run_en    = 1'($urandom_range(0, 1));
                samp();
                check("mc_ir", ir, ins);
                check("mc_irv", ir_valid, 1);
                check("mc_start", mc_start, (k == 1));
                check("mc_flag", multicycle_flag, 1);
                check("mc_trig", next_instr_trigger, (k == done_at));
                check("mc_pc", pc, m_pc);
                tick();
                if (k == done_at) begin
                    m_pc = (m_pc + 1) % 64;
                    if (hreq) m_halted = 1'b1;
                    break;
                end
                if (k == 15) begin
                    m_halted = 1'b1;
                    m_to     = 1'b1;
                end
            end
        end
        exec_done = 1'b0;
        halt_req  = 1'b0;
        run_en    = 1'b1;
        c2        = 1'b0;
    endtask

    initial begin
        int d;
        logic [3:0] op;
        rst_n = 1'b0; run_en = 1'b0; halt_req = 1'b0;
        instr = 16'h0000; c2 = 1'b0; exec_done = 1'b0;
        tick();
        tick();
        samp();
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 16'h0000);
        check("rst_irv", ir_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_to", mc_timeout, 0);
        check("rst_mcs", mc_start, 0);
        check("rst_mcf", multicycle_flag, 0);
        check("rst_trig", next_instr_trigger, 0);

        // idle without run_en, then a fetch abandoned by dropping run_en
        rst_n = 1'b1;
        tick();
        samp();
        check("idle_irv", ir_valid, 0);
        run_en = 1'b1;
        tick();
        instr  = 16'h4321;
        run_en = 1'b0;
        tick();
        samp();
        check("fetch_abort_ir", ir, 16'h0000);
        check("fetch_abort_irv", ir_valid, 0);
        run_en = 1'b1;
        tick();

        // straight-line ADDs
        for (int i = 0; i < 5; i++) do_instr(16'h4000, 1'b0, 0, 1'b0);
        check("add_pc5", pc, 5);

        // branches, including wrap-around
        do_instr(16'hF003, 1'b1, 0, 1'b0);
        check("br_pc9", pc, 9);
        do_instr(16'hF037, 1'b1, 0, 1'b0);
        check("br_pc1", pc, 1);
        do_instr(16'hF03E, 1'b1, 0, 1'b0);
        check("br_wrap", pc, 0);
        do_instr(16'hF03F, 1'b1, 0, 1'b0);
        check("br_minus1", pc, 0);

        // LOAD at pc=2 finishing in the third wait cycle, c2 held high
        do_instr(16'h4000, 1'b0, 0, 1'b0);
        do_instr(16'h4000, 1'b0, 0, 1'b0);
        do_instr(16'h8004, 1'b1, 3, 1'b0);
        check("load_pc3", pc, 3);
        // completion on the last allowed cycle beats the abort
        do_instr(16'hA000, 1'b0, 15, 1'b0);
        check("last_cycle_pc", pc, 4);
        check("last_cycle_to", mc_timeout, 0);

        // random instruction mix
        for (int i = 0; i < 40; i++) begin
            op = 4'($urandom_range(0, 15));
            do_instr({op, 12'($urandom)}, 1'($urandom_range(0, 1)),
                     int'($urandom_range(1, 14)), 1'b0);
        end

        // halt request during EXEC at pc=7
        d = (7 - m_pc - 1 + 128) % 64;
        do_instr({4'hF, 6'd0, 6'(d)}, 1'b1, 0, 1'b0);
        check("pre_halt_pc", pc, 7);
        do_instr(16'h4000, 1'b0, 0, 1'b1);
        samp();
        check("halt_pc", pc, 8);
        check("halt_flag", halted, 1);
        check("halt_irv", ir_valid, 0);
        for (int i = 0; i < 6; i++) begin
            instr     = 16'($urandom);
            run_en    = 1'($urandom_range(0, 1));
            c2        = 1'($urandom_range(0, 1));
            exec_done = 1'($urandom_range(0, 1));
            halt_req  = 1'($urandom_range(0, 1));
            tick();
            samp();
            check("frozen_pc", pc, 8);
            check("frozen_ir", ir, 16'h4000);
            check("frozen_halted", halted, 1);
        end

        // reset out of HALT; halt_req in IDLE goes straight to HALT
        rst_n = 1'b0; halt_req = 1'b0; exec_done = 1'b0; run_en = 1'b0;
        tick();
        rst_n = 1'b1;
        m_pc = 0; m_halted = 1'b0; m_to = 1'b0;
        samp();
        check("rst2_pc", pc, 0);
        check("rst2_halted", halted, 0);
        halt_req = 1'b1;
        run_en   = 1'b1;
        tick();
        samp();
        check("idle_halt", halted, 1);
        rst_n = 1'b0; halt_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // multicycle timeout: pc held, sticky flag, then a one-edge reset
        do_instr(16'h4000, 1'b0, 0, 1'b0);
        do_instr(16'h8004, 1'b0, 99, 1'b0);
        samp();
        check("to_halted", halted, 1);
        check("to_flag", mc_timeout, 1);
        check("to_pc", pc, 1);
        tick();
        samp();
        check("to_sticky", mc_timeout, 1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m_pc = 0; m_halted = 1'b0; m_to = 1'b0;
        samp();
        check("to_rst_pc", pc, 0);
        check("to_rst_flag", mc_timeout, 0);
        check("to_rst_halted", halted, 0);

        // reset on the same edge as exec_done in MC_WAIT
        run_en = 1'b1;
        tick();
        do_instr(16'h4000, 1'b0, 0, 1'b0);
        instr = 16'h9001;
        tick();
        exec_done = 1'b0;
        samp();
        check("mid_mcf", multicycle_flag, 1);
        tick();
        exec_done = 1'b1;
        rst_n     = 1'b0;
        samp();
        check("mid_trig_pre", next_instr_trigger, 1);
        tick();
        rst_n  = 1'b1;
        run_en = 1'b0;
        samp();
        check("mid_rst_pc", pc, 0);
        check("mid_rst_trig", next_instr_trigger, 0);
        check("mid_rst_irv", ir_valid, 0);
        check("mid_rst_mcf", multicycle_flag, 0);
        check("mid_rst_ir", ir, 16'h0000);
        exec_done = 1'b0;
        tick();
        samp();
        check("mid_idle_irv", ir_valid, 0);
        check("mid_idle_pc", pc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
